// File: rtl/clrst_led_if.sv
// Signal bundle between the servo colour-state source, the LED driver and the
// front-panel LED pins.
interface clrst_led_if #(
    parameter int PWM_BITS = 8
);
    logic [1:0]          clrst;
    logic [PWM_BITS-1:0] bright;
    logic                lamp_test;
    logic [1:0]          clr_q;
    logic                chg;
    logic                led_r;
    logic                led_g;
    logic                led_b;

    modport master (
        output clrst, bright, lamp_test,
        input  clr_q, chg, led_r, led_g, led_b
    );

    modport slave (
        input  clrst, bright, lamp_test,
        output clr_q, chg, led_r, led_g, led_b
    );
endinterface

// File: rtl/clrst_led_drv.sv
// Debounces the servo colour state and drives an RGB indicator with PWM
// brightness, blinking the out-of-range states.
module clrst_led_drv #(
    parameter int HOLD_CYCLES = 1000000,
    parameter int PWM_BITS    = 8,
    parameter int BLINK_BITS  = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    clrst_led_if.slave  bus
);
    localparam int             CW     = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]  HOLD_C = CW'(HOLD_CYCLES);

    logic [1:0]            in_q, in_d;
    logic [1:0]            cand_q, cand_d;
    logic [1:0]            clr_q, clr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  chg_q, chg_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
    logic [2:0]            led_q, led_d;

    logic [2:0] colour;
    logic       steady;
    logic       pwm_on;
    logic       blink_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q        <= 2'b00;
            cand_q      <= 2'b00;
            clr_q       <= 2'b00;
            cnt_q       <= '0;
            chg_q       <= 1'b0;
            pwm_cnt_q   <= '0;
            blink_cnt_q <= '0;
            led_q       <= 3'b000;
        end else begin
            in_q        <= in_d;
            cand_q      <= cand_d;
            clr_q       <= clr_d;
            cnt_q       <= cnt_d;
            chg_q       <= chg_d;
            pwm_cnt_q   <= pwm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            led_q       <= led_d;
        end
    end

    // Debounce: cnt tracks how long in_q has held a value differing from clr_q.
    always_comb begin
        in_d   = bus.clrst;
        cand_d = cand_q;
        clr_d  = clr_q;
        cnt_d  = cnt_q;
        chg_d  = 1'b0;
        if (in_q == clr_q) begin
            cand_d = in_q;
            cnt_d  = '0;
        end else if (in_q != cand_q) begin
            cand_d = in_q;
            cnt_d  = CW'(1);
        end else if (cnt_q == HOLD_C) begin
            clr_d  = cand_q;
            chg_d  = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d  = cnt_q + CW'(1);
        end
    end

    // Blink counter steps once per PWM period, on the pwm wrap edge.
    always_comb begin
        pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
        blink_cnt_d = blink_cnt_q;
        if (pwm_cnt_q == {PWM_BITS{1'b1}}) begin
            blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
        end
    end

    // Colour bits are {R,G,B}; only the two middle states are steady.
    always_comb begin
        colour = 3'b001;
        steady = 1'b0;
        case (clr_q)
            2'b00: begin colour = 3'b001; steady = 1'b0; end
            2'b01: begin colour = 3'b011; steady = 1'b1; end
            2'b10: begin colour = 3'b110; steady = 1'b1; end
            default: begin colour = 3'b100; steady = 1'b0; end
        endcase
        pwm_on   = (pwm_cnt_q < bus.bright);
        blink_on = ~blink_cnt_q[BLINK_BITS-1];
        led_d    = {3{bus.lamp_test}} | (colour & {3{pwm_on & (steady | blink_on)}});
    end

    assign bus.clr_q = clr_q;
    assign bus.chg   = chg_q;
    assign bus.led_r = led_q[2];
    assign bus.led_g = led_q[1];
    assign bus.led_b = led_q[0];
endmodule

// File: tb/tb_clrst_led_drv.sv
// Directed plus random stimulus for clrst_led_drv, checked every cycle against
// a behavioural model built from the hold-time and duty/blink rules.
module tb_clrst_led_drv;
    localparam int HOLD = 4;
    localparam int PB   = 4;
    localparam int BB   = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clrst_led_if #(.PWM_BITS(PB)) bus ();

    clrst_led_drv #(
        .HOLD_CYCLES(HOLD),
        .PWM_BITS   (PB),
        .BLINK_BITS (BB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int chg_seen = 0;

    // Model state: t = edges since reset release, hist = recent sampled inputs.
    int         t;
    logic [1:0] m_in;
    logic [1:0] m_disp;
    logic       m_chg;
    logic [2:0] m_led;
    logic [1:0] hist[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic void model_reset();
        t      = 0;
        m_in   = 2'b00;
        m_disp = 2'b00;
        m_chg  = 1'b0;
        m_led  = 3'b000;
        hist.delete();
    endfunction

    // Called just after a rising edge; inputs are still their pre-edge values.
    function automatic void model_edge();
        logic [2:0] col;
        logic       steady, pwm_on, blink_on, all_same;
        case (m_disp)
            2'd0: begin col = 3'b001; steady = 1'b0; end
            2'd1: begin col = 3'b011; steady = 1'b1; end
            2'd2: begin col = 3'b110; steady = 1'b1; end
            default: begin col = 3'b100; steady = 1'b0; end
        endcase
        pwm_on   = (t % (1 << PB)) < int'(bus.bright);
        blink_on = (t % (1 << (PB + BB))) < (1 << (PB + BB - 1));
        m_led    = {3{bus.lamp_test}} | (col & {3{pwm_on & (steady | blink_on)}});

        // A value shown after it has sat in the input register for HOLD+1 edges.
        hist.push_back(m_in);
        if (hist.size() > HOLD + 1) void'(hist.pop_front());
        all_same = (hist.size() == HOLD + 1);
        foreach (hist[i]) if (hist[i] !== hist[0]) all_same = 1'b0;
        m_chg = 1'b0;
        if (all_same && hist[0] !== m_disp) begin
            m_disp = hist[0];
            m_chg  = 1'b1;
        end
        m_in = bus.clrst;
        t++;
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (bus.chg === 1'b1) chg_seen++;
        check("clr_q", 8'(bus.clr_q), 8'(m_disp));
        check("chg",   8'(bus.chg),   8'(m_chg));
        check("led_r", 8'(bus.led_r), 8'(m_led[2]));
        check("led_g", 8'(bus.led_g), 8'(m_led[1]));
        check("led_b", 8'(bus.led_b), 8'(m_led[0]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Cycles observed until clr_q shows v, bounded to 20.
    task automatic wait_clr(input logic [1:0] v, output int k);
        k = 0;
        do begin
            cyc();
            k++;
        end while (bus.clr_q !== v && k < 20);
    endtask

    initial begin
        int k, cnt, c0;

        rst_n         = 1'b0;
        bus.clrst     = 2'b00;
        bus.bright    = 4'd15;
        bus.lamp_test = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_outs", 8'({bus.clr_q, bus.chg, bus.led_r, bus.led_g, bus.led_b}), 8'h00);
        rst_n = 1'b1;

        // Reach state 11 with LEDs active, then reset mid-run.
        bus.clrst = 2'b11;
        run(20);
        check("pre_rst_clr", 8'(bus.clr_q), 8'h3);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 8'({bus.clr_q, bus.chg, bus.led_r, bus.led_g, bus.led_b}), 8'h00);
        model_reset();
        bus.clrst = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(64);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            cyc();
            cnt += int'(bus.led_b);
        end
        check("blue_blink_duty", 8'(cnt), 8'd30);

        // Clean step 00 -> 10.
        bus.clrst = 2'b10;
        wait_clr(2'b10, k);
        check("step_latency", 8'(k), 8'd6);
        check("step_chg", 8'(bus.chg), 8'd1);
        run(3);

        // Glitch rejection from a settled 00.
        bus.clrst = 2'b00;
        run(10);
        c0 = chg_seen;
        bus.clrst = 2'b11;
        run(3);
        bus.clrst = 2'b00;
        run(10);
        check("glitch_clr", 8'(bus.clr_q), 8'h0);
        check("glitch_nochg", 8'(chg_seen - c0), 8'd0);
        bus.clrst = 2'b11;
        run(2);
        bus.clrst = 2'b01;
        wait_clr(2'b01, k);
        check("third_val_latency", 8'(k), 8'd6);

        // PWM duty on steady red/green.
        bus.clrst = 2'b10;
        run(10);
        bus.bright = 4'd4;
        run(2);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            cnt += int'(bus.led_r);
        end
        check("duty_4_of_16", 8'(cnt), 8'd4);
        bus.bright = 4'd0;
        run(1);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cyc();
            cnt += int'(bus.led_r | bus.led_g | bus.led_b);
        end
        check("bright0_dark", 8'(cnt), 8'd0);

        // Lamp test with dark brightness and state 00.
        bus.clrst = 2'b00;
        run(10);
        bus.lamp_test = 1'b1;
        cyc();
        check("lamp_on", 8'({bus.led_r, bus.led_g, bus.led_b}), 8'h7);
        bus.clrst = 2'b11;
        run(10);
        bus.lamp_test = 1'b0;
        bus.clrst = 2'b00;
        run(10);

        // Back-to-back transitions 00 -> 11 -> 01.
        bus.bright = 4'd9;
        c0 = chg_seen;
        bus.clrst = 2'b11;
        wait_clr(2'b11, k);
        check("b2b_first_lat", 8'(k), 8'd6);
        bus.clrst = 2'b01;
        wait_clr(2'b01, k);
        check("b2b_second_lat", 8'(k), 8'd6);
        run(4);
        check("b2b_two_pulses", 8'(chg_seen - c0), 8'd2);

        // Random segments checked against the model.
        for (int i = 0; i < 80; i++) begin
            bus.clrst     = 2'($urandom_range(3, 0));
            bus.bright    = 4'($urandom_range(15, 0));
            bus.lamp_test = ($urandom_range(7, 0) == 0);
            run($urandom_range(8, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
